multicycle_ctrl_fsm: RTL and testbench

// Control state machine for the multi-cycle RV32I core (successor to the single-cycle datapath):
// one instruction takes IF/ID/EX/MEM/WB steps over a shared, variable-latency memory port.

---
 rtl/multicycle_ctrl_fsm.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: IF/ID/EX/MEM/WB control for the multi-cycle RV32I core with memory handshake timeout
module multicycle_ctrl_fsm #(
  parameter int XLEN      = 32,
  parameter int HALT_CODE = 10,
  parameter int TIMEOUT   = 255,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             bcond,
  input  logic [XLEN-1:0]  x17,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op_sel,
  output logic             aluout_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             is_halted,
  output logic [1:0]       err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_HALT = 3'd5, S_ERR = 3'd6
  } state_t;

  state_t      st;
  logic        run;
  logic [15:0] wait_cnt;

  logic is_r, is_i, is_upper, is_load, is_store, is_br, is_jal, is_jalr, is_sys, legal;
  logic halt_req, timed_out;

  assign is_r      = opcode == OP_R;
  assign is_i      = opcode == OP_I;
  assign is_upper  = opcode == OP_LUI || opcode == OP_AUIPC;
  assign is_load   = opcode == OP_LOAD;
  assign is_store  = opcode == OP_STORE;
  assign is_br     = opcode == OP_BR;
  assign is_jal    = opcode == OP_JAL;
  assign is_jalr   = opcode == OP_JALR;
  assign is_sys    = opcode == OP_SYS;
  assign legal     = is_r | is_i | is_upper | is_load | is_store | is_br | is_jal | is_jalr | is_sys;
  assign halt_req  = is_sys && x17 == XLEN'(HALT_CODE);
  // wait_cnt counts earlier request cycles without ready; this is the last allowed one
  assign timed_out = mem_req && !mem_ready && wait_cnt == 16'(TIMEOUT - 1);
  assign state     = st;

  // datapath controls decoded from the current step, opcode and branch condition
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    i_or_d       = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'd0;
    alu_op_sel   = 2'd0;
    aluout_write = 1'b0;
    reg_write    = 1'b0;
    wb_sel       = 2'd0;
    is_halted    = 1'b0;
    case (st)
      S_IF: begin
        mem_req  = run;
        ir_write = run && mem_ready;
      end
      S_ID: begin
        alu_src_b    = 2'd1;
        aluout_write = 1'b1;
        pc_write     = is_sys && !halt_req;
      end
      S_EX: begin
        if (is_r || is_i) begin
          alu_src_a    = 1'b1;
          alu_src_b    = is_i ? 2'd1 : 2'd0;
          alu_op_sel   = 2'd1;
          aluout_write = 1'b1;
        end else if (is_upper) begin
          alu_src_b    = 2'd1;
          alu_op_sel   = 2'd1;
          aluout_write = 1'b1;
        end else if (is_load || is_store) begin
          alu_src_a    = 1'b1;
          alu_src_b    = 2'd1;
          aluout_write = 1'b1;
        end else if (is_br) begin
          alu_src_a  = 1'b1;
          alu_op_sel = 2'd2;
          pc_write   = 1'b1;
          pc_src     = bcond ? 2'd1 : 2'd0;
        end else if (is_jal) begin
          pc_write  = 1'b1;
          pc_src    = 2'd1;
          reg_write = 1'b1;
          wb_sel    = 2'd2;
        end else if (is_jalr) begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd1;
          pc_write  = 1'b1;
          pc_src    = 2'd2;
          reg_write = 1'b1;
          wb_sel    = 2'd2;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        i_or_d   = 1'b1;
        mem_we   = is_store;
        pc_write = is_store && mem_ready;
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = is_load ? 2'd1 : 2'd0;
        pc_write  = 1'b1;
      end
      default: is_halted = 1'b1;
    endcase
  end

  // step sequencing, sticky error code, request wait counter and retire counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= S_IF;
      run      <= 1'b0;
      err      <= 2'd0;
      wait_cnt <= 16'd0;
      instret  <= '0;
    end else begin
      run      <= 1'b1;
      instret  <= instret + CNT_W'(pc_write);
      wait_cnt <= (mem_req && !mem_ready) ? wait_cnt + 16'd1 : 16'd0;
      case (st)
        S_IF: begin
          if (timed_out) begin
            st  <= S_ERR;
            err <= 2'd2;
          end else if (mem_req && mem_ready) st <= S_ID;
        end
        S_ID: begin
          if (is_sys) st <= halt_req ? S_HALT : S_IF;
          else if (!legal) begin
            st  <= S_ERR;
            err <= 2'd1;
          end else st <= S_EX;
        end
        S_EX: st <= (is_load || is_store) ? S_MEM : (is_br || is_jal || is_jalr) ? S_IF : S_WB;
        S_MEM: begin
          if (timed_out) begin
            st  <= S_ERR;
            err <= 2'd2;
          end else if (mem_ready) st <= is_store ? S_IF : S_WB;
        end
        S_WB: st <= S_IF;
        default: st <= st;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: per-cycle trace check of the control FSM against an instruction-level expectation builder
module tb_multicycle_ctrl_fsm;
  localparam int TO = 4;
  localparam logic [6:0] R     = 7'b0110011;
  localparam logic [6:0] IA    = 7'b0010011;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] LD    = 7'b0000011;
  localparam logic [6:0] ST    = 7'b0100011;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] SYS   = 7'b1110011;
  localparam logic [6:0] BAD   = 7'b0001111;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode = '0;
  logic        bcond = 1'b0;
  logic [31:0] x17 = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_write, alu_src_a, aluout_write, reg_write, is_halted;
  logic [1:0]  pc_src, alu_src_b, alu_op_sel, wb_sel, err;
  logic [2:0]  state;
  logic [31:0] instret;

  multicycle_ctrl_fsm #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .x17(x17), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op_sel(alu_op_sel),
    .aluout_write(aluout_write), .reg_write(reg_write), .wb_sel(wb_sel), .is_halted(is_halted),
    .err(err), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  opc;
    logic        bc;
    logic [31:0] x;
    logic        rdy;
    logic [2:0]  st;
    logic        req, we, iod, ir, pcw;
    logic [1:0]  pcs;
    logic        rw;
    logic [1:0]  wbs;
    logic        hlt;
    logic [1:0]  er;
    logic [31:0] ret;
    logic        ac;
    logic [5:0]  alu;
  } cyc_t;

  typedef struct {
    logic [6:0]  o;
    logic        b;
    logic [31:0] x;
    int          il;
    int          ml;
  } ins_t;

  cyc_t q[$];
  int   ret;
  int   passed = 0;
  int   total = 0;
  int   ncyc = 0;

  function automatic cyc_t mk(logic [6:0] o, logic [2:0] s);
    cyc_t c;
    c = '{default: '0};
    c.opc = o;
    c.bc  = 1'($urandom);
    c.x   = $urandom;
    c.rdy = 1'($urandom);
    c.st  = s;
    c.ret = ret;
    return c;
  endfunction

  // queue one expected cycle; a PC update retires the instruction for the following cycles
  function automatic void emit(cyc_t c);
    q.push_back(c);
    if (c.pcw) ret++;
  endfunction

  function automatic void absorb(logic [6:0] o, logic [1:0] e);
    cyc_t c;
    for (int k = 0; k < 4; k++) begin
      c = mk(o, e != 0 ? 3'd6 : 3'd5);
      c.hlt = 1'b1;
      c.er  = e;
      emit(c);
    end
  endfunction

  // request cycles before ready; a request may stay up for at most TO cycles in total
  function automatic bit mem_wait(logic [6:0] o, logic [2:0] s, logic we, logic iod, int lat);
    cyc_t c;
    for (int k = 0; k < lat && k < TO; k++) begin
      c = mk(o, s);
      c.req = 1'b1;
      c.we  = we;
      c.iod = iod;
      c.rdy = 1'b0;
      emit(c);
    end
    if (lat >= TO) begin
      absorb(o, 2'd2);
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit legal(logic [6:0] o);
    return o inside {R, IA, LUI, AUIPC, LD, ST, BR, JAL, JALR, SYS};
  endfunction

  // expand one instruction into its expected cycles; returns 1 when the core ends up halted or in error
  function automatic bit add_instr(logic [6:0] o, logic b, logic [31:0] x, int il, int ml);
    cyc_t c;
    if (mem_wait(o, 3'd0, 1'b0, 1'b0, il)) return 1'b1;
    c = mk(o, 3'd0);
    c.req = 1'b1;
    c.rdy = 1'b1;
    c.ir  = 1'b1;
    emit(c);
    c = mk(o, 3'd1);
    c.x   = x;
    c.ac  = 1'b1;
    c.alu = 6'b1_0_01_00;
    if (o == SYS) begin
      if (x == 32'd10) begin
        emit(c);
        absorb(o, 2'd0);
        return 1'b1;
      end
      c.pcw = 1'b1;
      emit(c);
      return 1'b0;
    end
    emit(c);
    if (!legal(o)) begin
      absorb(o, 2'd1);
      return 1'b1;
    end
    c = mk(o, 3'd2);
    c.bc = b;
    if (o == BR) begin
      c.pcw = 1'b1;
      c.pcs = b ? 2'd1 : 2'd0;
      emit(c);
      return 1'b0;
    end
    if (o == JAL || o == JALR) begin
      c.pcw = 1'b1;
      c.pcs = o == JAL ? 2'd1 : 2'd2;
      c.rw  = 1'b1;
      c.wbs = 2'd2;
      emit(c);
      return 1'b0;
    end
    c.ac  = o inside {R, IA, LD, ST};
    c.alu = o == R ? 6'b1_1_00_01 : o == IA ? 6'b1_1_01_01 : 6'b1_1_01_00;
    emit(c);
    if (o == LD || o == ST) begin
      if (mem_wait(o, 3'd3, o == ST, 1'b1, ml)) return 1'b1;
      c = mk(o, 3'd3);
      c.req = 1'b1;
      c.we  = o == ST;
      c.iod = 1'b1;
      c.rdy = 1'b1;
      c.pcw = o == ST;
      emit(c);
      if (o == ST) return 1'b0;
    end
    c = mk(o, 3'd4);
    c.rw  = 1'b1;
    c.wbs = o == LD ? 2'd1 : 2'd0;
    c.pcw = 1'b1;
    emit(c);
    return 1'b0;
  endfunction

  task automatic check(cyc_t c);
    logic [47:0] e, g;
    logic [5:0]  ea, ga;
    e = {c.st, c.req, c.we, c.iod, c.ir, c.pcw, c.pcs, c.rw, c.wbs, c.hlt, c.er, c.ret};
    g = {state, mem_req, mem_req & mem_we, mem_req & i_or_d, c.st == 3'd3 ? c.ir : ir_write, pc_write,
         pc_write ? pc_src : 2'd0, reg_write, reg_write ? wb_sel : 2'd0, is_halted, err, instret};
    ea = c.ac ? c.alu : 6'd0;
    ga = c.ac ? {aluout_write, alu_src_a, alu_src_b, alu_op_sel} : 6'd0;
    total++;
    if (e == g && ea == ga) passed++;
    else $display("FAIL cycle%0d opc=%b got=%h/%h want=%h/%h", ncyc, c.opc, g, ga, e, ea);
  endtask

  // apply up to n queued cycles (n<0: all), checking outputs just after inputs settle
  task automatic run_n(int n);
    cyc_t c;
    int k = 0;
    while (q.size() > 0 && (n < 0 || k < n)) begin
      c = q.pop_front();
      @(negedge clk);
      opcode = c.opc;
      bcond = c.bc;
      x17 = c.x;
      mem_ready = c.rdy;
      #1 check(c);
      ncyc++;
      k++;
    end
    q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    total++;
    if (!mem_req && state == 3'd0 && instret == 0 && err == 2'd0 && !is_halted) passed++;
    else $display("FAIL reset_hold req=%b st=%0d instret=%0d err=%0d want 0/0/0/0", mem_req, state, instret, err);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    total++;
    if (!mem_req) passed++;
    else $display("FAIL reset_release req=%b want 0 before first clock", mem_req);
    ret = 0;
  endtask

  initial begin
    ins_t tbl[12];
    ins_t r;
    bit   dead;
    logic [6:0] ops[10];
    ops = '{R, IA, LUI, AUIPC, LD, ST, BR, JAL, JALR, SYS};
    tbl[0]  = '{R,     1'b0, 32'd0,  0, 0};
    tbl[1]  = '{LD,    1'b0, 32'd0,  3, 3};
    tbl[2]  = '{BR,    1'b1, 32'd0,  0, 0};
    tbl[3]  = '{BR,    1'b0, 32'd0,  1, 0};
    tbl[4]  = '{ST,    1'b0, 32'd0,  2, 1};
    tbl[5]  = '{JAL,   1'b0, 32'd0,  0, 0};
    tbl[6]  = '{JALR,  1'b0, 32'd0,  1, 0};
    tbl[7]  = '{IA,    1'b0, 32'd0,  0, 0};
    tbl[8]  = '{LUI,   1'b0, 32'd0,  0, 0};
    tbl[9]  = '{AUIPC, 1'b0, 32'd0,  2, 0};
    tbl[10] = '{SYS,   1'b0, 32'd9,  0, 0};
    tbl[11] = '{SYS,   1'b0, 32'd10, 0, 0};
    ret = 0;
    do_reset();
    foreach (tbl[i]) begin
      dead = add_instr(tbl[i].o, tbl[i].b, tbl[i].x, tbl[i].il, tbl[i].ml);
      if (dead) break;
    end
    run_n(-1);
    do_reset();
    dead = add_instr(LD, 1'b0, 32'd0, 0, 3);
    run_n(4);
    #2 do_reset();
    dead = add_instr(R, 1'b0, 32'd0, TO, 0);
    run_n(-1);
    do_reset();
    dead = add_instr(ST, 1'b0, 32'd0, TO - 1, TO - 1);
    dead = add_instr(LD, 1'b0, 32'd0, 0, 9);
    run_n(-1);
    do_reset();
    dead = add_instr(BAD, 1'b0, 32'd0, 1, 0);
    run_n(-1);
    do_reset();
    for (int i = 0; i < 60; i++) begin
      r.o  = ops[$urandom_range(0, 9)];
      r.b  = 1'($urandom);
      r.x  = $urandom;
      if (r.x == 32'd10) r.x = 32'd11;
      r.il = $urandom_range(0, TO - 1);
      r.ml = $urandom_range(0, TO - 1);
      dead = add_instr(r.o, r.b, r.x, r.il, r.ml);
    end
    run_n(-1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
